// File: rtl/buffer_ra_packer.sv
// Shift-in packer for the RMII receive path: sliding window plus
// word assembly with chunk count, alignment and partial flush.
module buffer_ra_packer #(
  parameter int BUFFER_SIZE = 8,
  parameter int INPUT_SIZE  = 2,
  parameter bit REVERSE     = 1'b0
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [INPUT_SIZE-1:0]  data_in,
  input  logic                   trigger,
  input  logic                   align_in,
  input  logic                   flush_in,
  output logic [BUFFER_SIZE-1:0] data_out,
  output logic [BUFFER_SIZE-1:0] word_out,
  output logic                   word_valid_out,
  output logic                   word_partial_out,
  output logic [$clog2(BUFFER_SIZE/INPUT_SIZE+1)-1:0] fill_out
);

  localparam int CHUNKS = BUFFER_SIZE / INPUT_SIZE;
  localparam int CW     = $clog2(CHUNKS + 1);

  logic [BUFFER_SIZE-1:0] sr_q, sr_d;
  logic [BUFFER_SIZE-1:0] word_q, word_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   valid_q, valid_d;
  logic                   partial_q, partial_d;

  logic [BUFFER_SIZE-1:0] win0;
  logic [BUFFER_SIZE-1:0] mask;
  logic [CW-1:0]          cnt_n;
  logic                   done;

  // Zero-latency window; win0 is the same window seen from an empty sr.
  if (REVERSE) begin : g_rev
    assign data_out = {data_in, sr_q[BUFFER_SIZE-1:INPUT_SIZE]};
    assign win0     = {data_in, {(BUFFER_SIZE-INPUT_SIZE){1'b0}}};
  end else begin : g_nor
    assign data_out = {sr_q[BUFFER_SIZE-INPUT_SIZE-1:0], data_in};
    assign win0     = {{(BUFFER_SIZE-INPUT_SIZE){1'b0}}, data_in};
  end

  // Next state: align wins, then trigger, then flush of what remains.
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    partial_d = 1'b0;
    cnt_n     = cnt_q;
    done      = 1'b0;
    mask      = '0;
    if (align_in) begin
      sr_d  = trigger ? win0 : '0;
      cnt_d = trigger ? CW'(1) : '0;
    end else begin
      if (trigger) begin
        sr_d = data_out;
        if (cnt_q == CW'(CHUNKS - 1)) begin
          word_d  = data_out;
          valid_d = 1'b1;
          cnt_n   = '0;
          done    = 1'b1;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      for (int i = 0; i < CHUNKS; i++) begin
        if (CW'(i) < cnt_n) begin
          if (REVERSE)
            mask[BUFFER_SIZE-(i+1)*INPUT_SIZE +: INPUT_SIZE] = '1;
          else
            mask[i*INPUT_SIZE +: INPUT_SIZE] = '1;
        end
      end
      if (flush_in && !done && cnt_n != '0) begin
        word_d    = sr_d & mask;
        valid_d   = 1'b1;
        partial_d = 1'b1;
        cnt_n     = '0;
      end
      cnt_d = cnt_n;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sr_q      <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      partial_q <= partial_d;
    end
  end

  assign word_out         = word_q;
  assign word_valid_out   = valid_q;
  assign word_partial_out = partial_q;
  assign fill_out         = cnt_q;

endmodule
